// File: rtl/a1339_spi_responder_if.sv
// SPI pad-side bundle between the sensor-polling master and the emulated A1339 responder.
interface a1339_spi_responder_if;
  logic sck_i;
  logic ss_n_i;
  logic mosi_i;
  logic miso_o;
  logic miso_oe_o;

  modport slave  (input sck_i, ss_n_i, mosi_i, output miso_o, miso_oe_o);
  modport master (output sck_i, ss_n_i, mosi_i, input miso_o, miso_oe_o);
endinterface

// File: rtl/a1339_spi_responder.sv
// A1339 angle-sensor emulator: SPI mode 3 slave with 20-bit frames; the reply to frame N is shifted out in frame N+1.
// Latency: pads pass through 2-FF synchronizers, then one EVAL cycle after ss_n rises; no backpressure, the master owns the bus timing.
module a1339_spi_responder #(
  parameter logic [5:0] ANGLE_ADDR = 6'h20,
  parameter logic [5:0] TURNS_ADDR = 6'h2C,
  parameter int         CNT_W      = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  a1339_spi_responder_if.slave spi,
  input  logic [11:0]          angle_i,
  input  logic [11:0]          turns_i,
  output logic [CNT_W-1:0]     frames_ok_o,
  output logic [CNT_W-1:0]     crc_errors_o,
  output logic [CNT_W-1:0]     frame_errors_o,
  output logic [15:0]          last_cmd_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_EVAL  = 2'd2;

  localparam logic [15:0] ERR_WORD = 16'h8000;

  // x^4+x+1, init 4'hF, MSB first.
  function automatic logic [3:0] crc4(input logic [15:0] w);
    logic [3:0] c;
    c = 4'hF;
    for (int i = 15; i >= 0; i--) begin
      if (c[3] ^ w[i]) c = {c[2:0], 1'b0} ^ 4'h3;
      else             c = {c[2:0], 1'b0};
    end
    return c;
  endfunction

  logic             sck_meta_q,  sck_meta_d;
  logic             sck_sync_q,  sck_sync_d;
  logic             sck_prev_q,  sck_prev_d;
  logic             ss_meta_q,   ss_meta_d;
  logic             ss_sync_q,   ss_sync_d;
  logic             ss_prev_q,   ss_prev_d;
  logic             mosi_meta_q, mosi_meta_d;
  logic             mosi_sync_q, mosi_sync_d;
  logic             armed_q,     armed_d;
  logic [1:0]       state_q,     state_d;
  logic [4:0]       bit_cnt_q,   bit_cnt_d;
  logic [19:0]      shift_out_q, shift_out_d;
  logic [19:0]      shift_in_q,  shift_in_d;
  logic [19:0]      pending_q,   pending_d;
  logic             miso_q,      miso_d;
  logic [CNT_W-1:0] frames_ok_q, frames_ok_d;
  logic [CNT_W-1:0] crc_err_q,   crc_err_d;
  logic [CNT_W-1:0] frame_err_q, frame_err_d;
  logic [15:0]      last_cmd_q,  last_cmd_d;

  logic        sck_rise, sck_fall, ss_rise, ss_fall;
  logic [15:0] rx_word;
  logic [3:0]  rx_crc;
  logic        crc_ok;
  logic [15:0] reply_word;

  assign sck_rise = sck_sync_q & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q & sck_prev_q;
  assign ss_rise  = ss_sync_q & ~ss_prev_q;
  // A fall only counts once ss_n has been seen high since reset.
  assign ss_fall  = armed_q & ss_prev_q & ~ss_sync_q;

  assign rx_word = shift_in_q[19:4];
  assign rx_crc  = shift_in_q[3:0];
  assign crc_ok  = (crc4(rx_word) == rx_crc);

  always_comb begin
    reply_word = ERR_WORD;
    if (rx_word[14])                      reply_word = 16'h0000;
    else if (rx_word[13:8] == ANGLE_ADDR) reply_word = {4'h0, angle_i};
    else if (rx_word[13:8] == TURNS_ADDR) reply_word = {4'h0, turns_i};
  end

  always_comb begin
    sck_meta_d  = spi.sck_i;
    sck_sync_d  = sck_meta_q;
    sck_prev_d  = sck_sync_q;
    ss_meta_d   = spi.ss_n_i;
    ss_sync_d   = ss_meta_q;
    ss_prev_d   = ss_sync_q;
    mosi_meta_d = spi.mosi_i;
    mosi_sync_d = mosi_meta_q;
    armed_d     = armed_q | ss_sync_q;

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_out_d = shift_out_q;
    shift_in_d  = shift_in_q;
    pending_d   = pending_q;
    miso_d      = miso_q;
    frames_ok_d = frames_ok_q;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;
    last_cmd_d  = last_cmd_q;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b1;
        if (ss_fall) begin
          state_d     = ST_SHIFT;
          shift_out_d = pending_q;
          shift_in_d  = 20'h0;
          bit_cnt_d   = 5'd0;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d = ST_EVAL;
          miso_d  = 1'b1;
        end else begin
          if (sck_fall) begin
            miso_d      = shift_out_q[19];
            shift_out_d = {shift_out_q[18:0], 1'b0};
          end
          if (sck_rise) begin
            shift_in_d = {shift_in_q[18:0], mosi_sync_q};
            if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      ST_EVAL: begin
        state_d = ST_IDLE;
        miso_d  = 1'b1;
        if (bit_cnt_q != 5'd20) begin
          if (frame_err_q != '1) frame_err_d = frame_err_q + 1'b1;
        end else if (!crc_ok) begin
          if (crc_err_q != '1) crc_err_d = crc_err_q + 1'b1;
          pending_d = {ERR_WORD, crc4(ERR_WORD)};
        end else begin
          if (frames_ok_q != '1) frames_ok_d = frames_ok_q + 1'b1;
          last_cmd_d = rx_word;
          pending_d  = {reply_word, crc4(reply_word)};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ss_n syncs reset low so a select held across reset never looks like a fresh fall.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sck_meta_q  <= 1'b1;
      sck_sync_q  <= 1'b1;
      sck_prev_q  <= 1'b1;
      ss_meta_q   <= 1'b0;
      ss_sync_q   <= 1'b0;
      ss_prev_q   <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 5'd0;
      shift_out_q <= 20'h0;
      shift_in_q  <= 20'h0;
      pending_q   <= 20'h0000D;
      miso_q      <= 1'b1;
      frames_ok_q <= '0;
      crc_err_q   <= '0;
      frame_err_q <= '0;
      last_cmd_q  <= 16'h0;
    end else begin
      sck_meta_q  <= sck_meta_d;
      sck_sync_q  <= sck_sync_d;
      sck_prev_q  <= sck_prev_d;
      ss_meta_q   <= ss_meta_d;
      ss_sync_q   <= ss_sync_d;
      ss_prev_q   <= ss_prev_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_out_q <= shift_out_d;
      shift_in_q  <= shift_in_d;
      pending_q   <= pending_d;
      miso_q      <= miso_d;
      frames_ok_q <= frames_ok_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      last_cmd_q  <= last_cmd_d;
    end
  end

  assign spi.miso_o     = miso_q;
  assign spi.miso_oe_o  = ~ss_sync_q & armed_q;
  assign frames_ok_o    = frames_ok_q;
  assign crc_errors_o   = crc_err_q;
  assign frame_errors_o = frame_err_q;
  assign last_cmd_o     = last_cmd_q;

endmodule

// File: tb/tb_a1339_spi_responder.sv
// Directed bench for the A1339 responder: plays the polling master and checks replies and counters.
module tb_a1339_spi_responder;

  logic        clock;
  logic        reset_n;
  logic [11:0] angle_i;
  logic [11:0] turns_i;
  logic [15:0] frames_ok_o;
  logic [15:0] crc_errors_o;
  logic [15:0] frame_errors_o;
  logic [15:0] last_cmd_o;

  a1339_spi_responder_if spi_if ();

  a1339_spi_responder #(
    .ANGLE_ADDR (6'h20),
    .TURNS_ADDR (6'h2C),
    .CNT_W      (16)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .spi            (spi_if),
    .angle_i        (angle_i),
    .turns_i        (turns_i),
    .frames_ok_o    (frames_ok_o),
    .crc_errors_o   (crc_errors_o),
    .frame_errors_o (frame_errors_o),
    .last_cmd_o     (last_cmd_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One SCK cycle in mode 3: master updates MOSI on the fall, samples MISO just before the rise.
  task automatic sck_bit(input logic b, inout logic [19:0] rx);
    spi_if.sck_i  = 1'b0;
    spi_if.mosi_i = b;
    cyc(8);
    rx = {rx[18:0], spi_if.miso_o};
    spi_if.sck_i = 1'b1;
    cyc(8);
  endtask

  task automatic spi_frame(input logic [19:0] tx, input int n, output logic [19:0] rx,
                           output logic oe_mid);
    rx = 20'h0;
    spi_if.ss_n_i = 1'b0;
    cyc(8);
    oe_mid = spi_if.miso_oe_o;
    for (int i = 0; i < n; i++) sck_bit(tx[19-i], rx);
    spi_if.ss_n_i = 1'b1;
    cyc(10);
  endtask

  logic [19:0] rx;
  logic        oe;
  int          revs;

  initial begin
    reset_n       = 1'b0;
    spi_if.sck_i  = 1'b1;
    spi_if.ss_n_i = 1'b1;
    spi_if.mosi_i = 1'b0;
    angle_i       = 12'hABC;
    turns_i       = 12'hFFE;
    cyc(4);
    reset_n = 1'b1;
    cyc(10);

    chk("reset_miso",      {31'h0, spi_if.miso_o},    32'h1);
    chk("reset_oe",        {31'h0, spi_if.miso_oe_o}, 32'h0);
    chk("reset_frames_ok", {16'h0, frames_ok_o},      32'h0);
    chk("reset_crc_err",   {16'h0, crc_errors_o},     32'h0);
    chk("reset_frame_err", {16'h0, frame_errors_o},   32'h0);
    chk("reset_last_cmd",  {16'h0, last_cmd_o},       32'h0);

    // Read angle: first reply is the reset pending word 0x0000 with CRC 0xD.
    spi_frame(20'h20009, 20, rx, oe);
    chk("a_miso",      {12'h0, rx},          32'h0000D);
    chk("a_oe_mid",    {31'h0, oe},          32'h1);
    chk("a_oe_after",  {31'h0, spi_if.miso_oe_o}, 32'h0);
    chk("a_frames_ok", {16'h0, frames_ok_o}, 32'h1);
    chk("a_last_cmd",  {16'h0, last_cmd_o},  32'h2000);

    // Read turns: reply carries angle 0xABC with CRC 0x7.
    spi_frame(20'h2C001, 20, rx, oe);
    chk("b_miso",      {12'h0, rx},          32'h0ABC7);
    chk("b_frames_ok", {16'h0, frames_ok_o}, 32'h2);
    chk("b_last_cmd",  {16'h0, last_cmd_o},  32'h2C00);

    // Reply carries turns 0xFFE (CRC 0x0), which is -2 as a signed 12-bit count.
    spi_frame(20'h20009, 20, rx, oe);
    chk("c_miso", {12'h0, rx}, 32'h0FFE0);
    revs = {{20{rx[15]}}, rx[15:4]};
    chk("c_revs",      revs,                 -32'sd2);
    chk("c_frames_ok", {16'h0, frames_ok_o}, 32'h3);

    // Bad CRC frame.
    spi_frame(20'h20000, 20, rx, oe);
    chk("d_miso",      {12'h0, rx},          32'h0ABC7);
    chk("d_crc_err",   {16'h0, crc_errors_o}, 32'h1);
    chk("d_frames_ok", {16'h0, frames_ok_o}, 32'h3);
    chk("d_last_cmd",  {16'h0, last_cmd_o},  32'h2000);

    // Short frame of 12 edges: leading 12 bits of the error reply 0x8000E.
    spi_frame(20'h20009, 12, rx, oe);
    chk("e_miso12",    {20'h0, rx[11:0]},      32'h800);
    chk("e_frame_err", {16'h0, frame_errors_o}, 32'h1);
    chk("e_frames_ok", {16'h0, frames_ok_o},   32'h3);
    chk("e_crc_err",   {16'h0, crc_errors_o},  32'h1);

    // Pending error reply survives the short frame.
    spi_frame(20'h20009, 20, rx, oe);
    chk("f_miso",      {12'h0, rx},          32'h8000E);
    chk("f_frames_ok", {16'h0, frames_ok_o}, 32'h4);

    // One-cycle reset after 8 edges; rest of the frame must be ignored.
    rx = 20'h0;
    spi_if.ss_n_i = 1'b0;
    cyc(8);
    for (int i = 0; i < 8; i++) sck_bit(1'b0, rx);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) sck_bit(1'b1, rx);
    chk("r_miso_ignored", {20'h0, rx[11:0]}, 32'hFFF);
    chk("r_oe_ignored",   {31'h0, spi_if.miso_oe_o}, 32'h0);
    spi_if.ss_n_i = 1'b1;
    cyc(10);
    chk("r_frames_ok", {16'h0, frames_ok_o},    32'h0);
    chk("r_crc_err",   {16'h0, crc_errors_o},   32'h0);
    chk("r_frame_err", {16'h0, frame_errors_o}, 32'h0);
    chk("r_last_cmd",  {16'h0, last_cmd_o},     32'h0);

    spi_frame(20'h20009, 20, rx, oe);
    chk("g_miso",      {12'h0, rx},          32'h0000D);
    chk("g_frames_ok", {16'h0, frames_ok_o}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
